// File: rtl/store_buffer.sv
// store_buffer: circular FIFO store buffer between the core and data memory; define STB_FORWARD_EN to forward buffered store data to hitting loads instead of stalling them
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata
);
  localparam int AW = $clog2(DEPTH);
`ifdef STB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_ld;
  logic          w_enq;
  logic          w_ret;
  logic          w_hit;
  logic [31:0]   w_fwd;
  assign w_full    = r_count == (AW+1)'(DEPTH);
  assign w_ld      = memread & ~memwrite;
  assign w_enq     = memwrite & ~w_full;
  assign w_ret     = mem_we & mem_ready;
  assign mem_we    = r_count != '0;
  assign mem_waddr = r_addr[r_head];
  assign mem_wdata = r_data[r_head];
  assign mem_raddr = aluout;
  assign stall     = (memwrite & w_full) | (~FWD & w_ld & w_hit);
  assign readdata  = (FWD & w_ld & w_hit) ? w_fwd : mem_rdata;
  // scan valid entries oldest to youngest so the last match is the youngest
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((AW+1)'(k) < r_count && r_addr[r_head + AW'(k)][31:2] == aluout[31:2]) begin
        w_hit = 1'b1;
        w_fwd = r_data[r_head + AW'(k)];
      end
    end
  end
  // entry payload needs no reset: validity comes from head and count
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= aluout;
      r_data[r_tail] <= writedata;
    end
  end
  // pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + 1'b1;
      if (w_ret) r_head <= r_head + 1'b1;
      r_count <= r_count + (AW+1)'(w_enq) - (AW+1)'(w_ret);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random checks of store_buffer against a queue model
module tb_store_buffer;
  localparam int DEPTH = 4;
`ifdef STB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [31:0] aluout = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        stall;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  int          tests = 0;
  int          fails = 0;
  bit          run = 1'b0;
  ent_t        q[$];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
    .aluout(aluout), .writedata(writedata), .readdata(readdata), .stall(stall),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = {mem_raddr[31:2], 2'b00} ^ 32'h5A5A_0000;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // model state update: enqueue decision uses occupancy before this edge's retire
  always @(posedge clk) begin
    if (reset) q.delete();
    else begin
      bit enq;
      bit ret;
      enq = memwrite && q.size() < DEPTH;
      ret = q.size() > 0 && mem_ready;
      if (ret) void'(q.pop_front());
      if (enq) q.push_back('{aluout, writedata});
    end
  end

  // every-cycle comparison of outputs against the model
  always @(negedge clk) begin
    if (run && !reset) begin
      bit hit;
      bit es;
      logic [31:0] fd;
      hit = 1'b0;
      fd = '0;
      foreach (q[i]) if (q[i].a[31:2] == aluout[31:2]) begin
        hit = 1'b1;
        fd = q[i].d;
      end
      es = (memwrite && q.size() == DEPTH) || (!FWD && memread && !memwrite && hit);
      chk("raddr", mem_raddr, aluout);
      chk("mem_we", {31'b0, mem_we}, {31'b0, q.size() > 0});
      chk("stall", {31'b0, stall}, {31'b0, es});
      if (q.size() > 0) begin
        chk("waddr", mem_waddr, q[0].a);
        chk("wdata", mem_wdata, q[0].d);
      end
      if (!memread) chk("rd_idle", readdata, mem_rdata);
      else if (!memwrite && !es) chk("rd_load", readdata, (FWD && hit) ? fd : mem_rdata);
    end
  end

  task automatic drive(input bit mw, input bit mr, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    @(posedge clk);
    #1;
    memwrite = mw;
    memread = mr;
    aluout = a;
    writedata = wd;
    mem_ready = rdy;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    memwrite = 1'b0;
    memread = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run = 1'b1;
    drive(1, 0, 32'h10, 32'hDEAD_BEEF, 1);
    chk("t33_stall", {31'b0, stall}, 32'd0);
    chk("t33_we0", {31'b0, mem_we}, 32'd0);
    drive(0, 0, 32'h0, 32'h0, 1);
    chk("t33_we", {31'b0, mem_we}, 32'd1);
    chk("t33_waddr", mem_waddr, 32'h10);
    chk("t33_wdata", mem_wdata, 32'hDEAD_BEEF);
    drive(0, 0, 32'h0, 32'h0, 1);
    chk("t33_empty", {31'b0, mem_we}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 32'h100 + 32'(4 * i), 32'(i + 1), 0);
      chk("t34_stall", {31'b0, stall}, {31'b0, i == 4});
    end
    drive(1, 0, 32'h110, 32'd5, 1);
    chk("t34_full_stall", {31'b0, stall}, 32'd1);
    chk("t34_w0", mem_waddr, 32'h100);
    drive(1, 0, 32'h110, 32'd5, 1);
    chk("t34_unstall", {31'b0, stall}, 32'd0);
    chk("t34_w1", mem_waddr, 32'h104);
    for (int i = 2; i < 5; i++) begin
      drive(0, 0, 32'h0, 32'h0, 1);
      chk("t34_order", mem_waddr, 32'h100 + 32'(4 * i));
      chk("t34_odata", mem_wdata, 32'(i + 1));
    end
    drive(0, 0, 32'h0, 32'h0, 1);
    chk("t34_drained", {31'b0, mem_we}, 32'd0);
    drive(1, 0, 32'h20, 32'd1, 0);
    drive(1, 0, 32'h20, 32'd2, 0);
    drive(0, 1, 32'h23, 32'h0, 0);
    if (FWD) chk("t35_fwd", readdata, 32'd2);
    chk("t35_stall", {31'b0, stall}, {31'b0, !FWD});
    drive(0, 1, 32'h23, 32'h0, 1);
    chk("t35_stall_a", {31'b0, stall}, {31'b0, !FWD});
    drive(0, 1, 32'h23, 32'h0, 1);
    chk("t35_stall_b", {31'b0, stall}, {31'b0, !FWD});
    if (FWD) chk("t35_fwd_b", readdata, 32'd2);
    drive(0, 1, 32'h23, 32'h0, 1);
    chk("t35_done", {31'b0, stall}, 32'd0);
    chk("t35_mem", readdata, 32'h5A5A_0020);
    drive(1, 0, 32'h44, 32'd7, 0);
    drive(0, 1, 32'h40, 32'h0, 0);
    chk("t36_stall", {31'b0, stall}, 32'd0);
    chk("t36_rd", readdata, 32'h5A5A_0040);
    drive(1, 0, 32'h48, 32'd8, 0);
    drive(1, 0, 32'h4C, 32'd9, 0);
    do_reset();
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("t37_we", {31'b0, mem_we}, 32'd0);
    chk("t37_stall", {31'b0, stall}, 32'd0);
    drive(0, 0, 32'h0, 32'h0, 1);
    chk("t37_nowrite", {31'b0, mem_we}, 32'd0);
    drive(1, 0, 32'h200, 32'hA0, 1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 32'h204 + 32'(4 * i), 32'hA1 + 32'(i), 1);
      chk("t38_waddr", mem_waddr, 32'h200 + 32'(4 * i));
      chk("t38_wdata", mem_wdata, 32'hA0 + 32'(i));
      chk("t38_stall", {31'b0, stall}, 32'd0);
    end
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      reset = $urandom_range(0, 255) == 0;
      memwrite = $urandom_range(0, 9) < 4;
      memread = $urandom_range(0, 9) < 4;
      aluout = 32'h300 + 32'($urandom_range(0, 31));
      writedata = $urandom;
      mem_ready = $urandom_range(0, 1) == 1;
    end
    @(posedge clk);
    #1;
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
